// File: rtl/demux18_capture.sv
// Registered 1-to-8 demultiplexer with write tracking, auto-increment pointer and fill FSM.
// Optional even-parity output P is generated when DEMUX18_PARITY_EN is defined.
module demux18_capture (
  input  logic       clock,
  input  logic       reset,
  input  logic       D,
  input  logic [2:0] S,
  input  logic       ENb,
  input  logic       VALID,
  input  logic       AUTO,
  input  logic       CLR,
  output logic       READY,
  output logic [7:0] Q,
  output logic [7:0] QB,
  output logic [7:0] WMASK,
  output logic       FULL,
  output logic       DONE,
  output logic       P
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] mem_q, mem_d;
  logic [7:0] wmask_q, wmask_d;
  logic [2:0] ptr_q, ptr_d;
  logic       done_q;
  logic       write_en;
  logic [2:0] addr;

  // HOLD blocks writes until CLR; ENb freezes everything except CLR.
  assign write_en = VALID && !ENb && (state_q != HOLD);
  assign addr     = AUTO ? ptr_q : S;

  always_comb begin
    mem_d   = mem_q;
    wmask_d = wmask_q;
    ptr_d   = ptr_q;
    if (write_en) begin
      mem_d[addr]   = D;
      wmask_d[addr] = 1'b1;
      if (AUTO) begin
        ptr_d = ptr_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      mem_q   <= 8'h00;
      wmask_q <= 8'h00;
      ptr_q   <= 3'd0;
      done_q  <= 1'b0;
    end else if (CLR) begin
      state_q <= IDLE;
      mem_q   <= 8'h00;
      wmask_q <= 8'h00;
      ptr_q   <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wmask_q <= wmask_d;
      ptr_q   <= ptr_d;
      done_q  <= 1'b0;
      if (write_en) begin
        // Only a write can complete the mask, and HOLD admits none, so DONE fires once per fill.
        if (wmask_d == 8'hFF) begin
          state_q <= HOLD;
          done_q  <= 1'b1;
        end else begin
          state_q <= FILL;
        end
      end
    end
  end

  assign READY = (state_q != HOLD);
  assign WMASK = wmask_q;
  assign FULL  = (wmask_q == 8'hFF);
  assign DONE  = done_q;
  assign Q     = ENb ? 8'h00 : mem_q;
  assign QB    = ~Q;

`ifdef DEMUX18_PARITY_EN
  assign P = ^Q;
`else
  assign P = 1'b0;
`endif

endmodule

// File: tb/tb_demux18_capture.sv
// Scoreboard bench for demux18_capture: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_demux18_capture;

  logic       clock;
  logic       reset;
  logic       D;
  logic [2:0] S;
  logic       ENb;
  logic       VALID;
  logic       AUTO;
  logic       CLR;
  logic       READY;
  logic [7:0] Q;
  logic [7:0] QB;
  logic [7:0] WMASK;
  logic       FULL;
  logic       DONE;
  logic       P;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic [7:0] wmask;
    logic       full;
    logic       done;
    logic       ready;
  } expect_t;

  expect_t scoreboard[$];
  int vectorsApplied = 0;
  int miscompares    = 0;

  demux18_capture dut (
    .clock (clock),
    .reset (reset),
    .D     (D),
    .S     (S),
    .ENb   (ENb),
    .VALID (VALID),
    .AUTO  (AUTO),
    .CLR   (CLR),
    .READY (READY),
    .Q     (Q),
    .QB    (QB),
    .WMASK (WMASK),
    .FULL  (FULL),
    .DONE  (DONE),
    .P     (P)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic expParity(input logic [7:0] q);
`ifdef DEMUX18_PARITY_EN
    return ^q;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle of inputs, then queue what the outputs must show after that edge.
  task automatic applyStimulus(
    input string      name,
    input logic       rst,
    input logic       enb,
    input logic       valid,
    input logic       d,
    input logic [2:0] s,
    input logic       autoMode,
    input logic       clr,
    input logic [7:0] eq,
    input logic [7:0] ewmask,
    input logic       efull,
    input logic       edone,
    input logic       eready
  );
    expect_t e;
    reset = rst;
    ENb   = enb;
    VALID = valid;
    D     = d;
    S     = s;
    AUTO  = autoMode;
    CLR   = clr;
    @(posedge clock);
    e.name  = name;
    e.q     = eq;
    e.wmask = ewmask;
    e.full  = efull;
    e.done  = edone;
    e.ready = eready;
    scoreboard.push_back(e);
    vectorsApplied++;
    @(negedge clock);
    #1;
  endtask

  task automatic checkOutput(input expect_t e);
    if (Q !== e.q) begin
      miscompares++;
      $display("[TB] FAIL %s Q: got %h want %h", e.name, Q, e.q);
    end
    if (QB !== ~e.q) begin
      miscompares++;
      $display("[TB] FAIL %s QB: got %h want %h", e.name, QB, ~e.q);
    end
    if (WMASK !== e.wmask) begin
      miscompares++;
      $display("[TB] FAIL %s WMASK: got %h want %h", e.name, WMASK, e.wmask);
    end
    if (FULL !== e.full) begin
      miscompares++;
      $display("[TB] FAIL %s FULL: got %b want %b", e.name, FULL, e.full);
    end
    if (DONE !== e.done) begin
      miscompares++;
      $display("[TB] FAIL %s DONE: got %b want %b", e.name, DONE, e.done);
    end
    if (READY !== e.ready) begin
      miscompares++;
      $display("[TB] FAIL %s READY: got %b want %b", e.name, READY, e.ready);
    end
    if (P !== expParity(e.q)) begin
      miscompares++;
      $display("[TB] FAIL %s P: got %b want %b", e.name, P, expParity(e.q));
    end
  endtask

  // Monitor: every negedge, check the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (scoreboard.size() > 0) begin
        checkOutput(scoreboard.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; ENb = 1'b1; VALID = 1'b0; D = 1'b0; S = 3'd0; AUTO = 1'b0; CLR = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;

    //             name          rst enb v  d  s    au clr  Q      WMASK  F  Dn R
    applyStimulus("reset_wr",    1, 0, 1, 1, 3'd0, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    applyStimulus("enb_block",   0, 1, 1, 1, 3'd3, 0, 0, 8'h00, 8'h00, 0, 0, 1);

    applyStimulus("auto0",       0, 0, 1, 1, 3'd0, 1, 0, 8'h01, 8'h01, 0, 0, 1);
    applyStimulus("auto1",       0, 0, 1, 0, 3'd0, 1, 0, 8'h01, 8'h03, 0, 0, 1);
    applyStimulus("auto2",       0, 0, 1, 1, 3'd0, 1, 0, 8'h05, 8'h07, 0, 0, 1);
    applyStimulus("auto3",       0, 0, 1, 0, 3'd0, 1, 0, 8'h05, 8'h0F, 0, 0, 1);
    applyStimulus("auto4",       0, 0, 1, 1, 3'd0, 1, 0, 8'h15, 8'h1F, 0, 0, 1);
    applyStimulus("auto5",       0, 0, 1, 0, 3'd0, 1, 0, 8'h15, 8'h3F, 0, 0, 1);
    applyStimulus("auto6",       0, 0, 1, 1, 3'd0, 1, 0, 8'h55, 8'h7F, 0, 0, 1);
    applyStimulus("auto7_full",  0, 0, 1, 0, 3'd0, 1, 0, 8'h55, 8'hFF, 1, 1, 0);
    applyStimulus("hold_ignore", 0, 0, 1, 1, 3'd0, 1, 0, 8'h55, 8'hFF, 1, 0, 0);
    applyStimulus("hold_gate",   0, 1, 0, 0, 3'd0, 0, 0, 8'h00, 8'hFF, 1, 0, 0);
    applyStimulus("hold_ungate", 0, 0, 0, 0, 3'd0, 0, 0, 8'h55, 8'hFF, 1, 0, 0);
    applyStimulus("clr_hold",    0, 0, 0, 0, 3'd0, 0, 1, 8'h00, 8'h00, 0, 0, 1);

    applyStimulus("addr5_d1",    0, 0, 1, 1, 3'd5, 0, 0, 8'h20, 8'h20, 0, 0, 1);
    applyStimulus("addr5_d0",    0, 0, 1, 0, 3'd5, 0, 0, 8'h00, 8'h20, 0, 0, 1);
    applyStimulus("clr_vs_wr",   0, 0, 1, 1, 3'd6, 1, 1, 8'h00, 8'h00, 0, 0, 1);
    applyStimulus("ptr_is_0",    0, 0, 1, 1, 3'd6, 1, 0, 8'h01, 8'h01, 0, 0, 1);
    applyStimulus("reset_mid",   1, 0, 1, 1, 3'd4, 0, 0, 8'h00, 8'h00, 0, 0, 1);

    applyStimulus("par_s0",      0, 0, 1, 1, 3'd0, 0, 0, 8'h01, 8'h01, 0, 0, 1);
    applyStimulus("par_s1",      0, 0, 1, 1, 3'd1, 0, 0, 8'h03, 8'h03, 0, 0, 1);
    applyStimulus("par_q07",     0, 0, 1, 1, 3'd2, 0, 0, 8'h07, 8'h07, 0, 0, 1);
    applyStimulus("par_q03",     0, 0, 1, 0, 3'd2, 0, 0, 8'h03, 8'h07, 0, 0, 1);

    applyStimulus("mix_ptr0",    0, 0, 1, 1, 3'd5, 1, 0, 8'h03, 8'h07, 0, 0, 1);
    applyStimulus("mix_ptr1",    0, 0, 1, 1, 3'd5, 1, 0, 8'h03, 8'h07, 0, 0, 1);
    applyStimulus("mix_addr7",   0, 0, 1, 1, 3'd7, 0, 0, 8'h83, 8'h87, 0, 0, 1);
    applyStimulus("mix_ptr2",    0, 0, 1, 1, 3'd7, 1, 0, 8'h87, 8'h87, 0, 0, 1);
    applyStimulus("mix_s3",      0, 0, 1, 0, 3'd3, 0, 0, 8'h87, 8'h8F, 0, 0, 1);
    applyStimulus("mix_s4",      0, 0, 1, 0, 3'd4, 0, 0, 8'h87, 8'h9F, 0, 0, 1);
    applyStimulus("mix_s5",      0, 0, 1, 0, 3'd5, 0, 0, 8'h87, 8'hBF, 0, 0, 1);
    applyStimulus("mix_full",    0, 0, 1, 1, 3'd6, 0, 0, 8'hC7, 8'hFF, 1, 1, 0);
    applyStimulus("done_once",   0, 0, 0, 0, 3'd0, 0, 0, 8'hC7, 8'hFF, 1, 0, 0);
    applyStimulus("done_quiet",  0, 0, 1, 0, 3'd6, 0, 0, 8'hC7, 8'hFF, 1, 0, 0);

    for (int i = 0; i < 10 && scoreboard.size() > 0; i++) begin
      @(posedge clock);
    end
    if (scoreboard.size() > 0) begin
      miscompares += scoreboard.size();
      $display("[TB] FAIL drain: got %0d pending want 0", scoreboard.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
